// File: rtl/pipeline_hazard_ctrl_if.sv
// ============================================================================
//  pipeline_hazard_ctrl_if
//  Decode/EX hazard inputs and stage-buffer control outputs of the controller.
//  Optional feature macro: PIPECTRL_PERF_EN (adds stall_count)
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface pipeline_hazard_ctrl_if #(
    parameter int REG_BITS = 4
);
    logic [REG_BITS-1:0] id_rs1;
    logic [REG_BITS-1:0] id_rs2;
    logic                id_use_rs1;
    logic                id_use_rs2;
    logic                id_halt;
    logic                ex_mem_read;
    logic [REG_BITS-1:0] ex_rd;
    logic                ex_branch_taken;
    logic                ex_muldiv;
    logic                pc_write;
    logic                ifid_write;
    logic                idex_write;
    logic                ifid_flush;
    logic                idex_flush;
    logic                exmem_flush;
    logic                halted;
`ifdef PIPECTRL_PERF_EN
    logic [15:0]         stall_count;
`endif

    modport master (
`ifdef PIPECTRL_PERF_EN
        input  stall_count,
`endif
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
        output ex_mem_read, ex_rd, ex_branch_taken, ex_muldiv,
        input  pc_write, ifid_write, idex_write,
        input  ifid_flush, idex_flush, exmem_flush, halted
    );

    modport slave (
`ifdef PIPECTRL_PERF_EN
        output stall_count,
`endif
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_halt,
        input  ex_mem_read, ex_rd, ex_branch_taken, ex_muldiv,
        output pc_write, ifid_write, idex_write,
        output ifid_flush, idex_flush, exmem_flush, halted
    );
endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
//  pipeline_hazard_ctrl
//  Stall/flush/halt sequencing for the five-stage pipeline buffers and PC.
//  Optional feature macro: PIPECTRL_PERF_EN (16-bit saturating stall counter)
//  Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
    parameter int MULDIV_CYCLES = 4,
    parameter int REG_BITS      = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam logic [1:0] c_st_run    = 2'd0;
    localparam logic [1:0] c_st_muldiv = 2'd1;
    localparam logic [1:0] c_st_halt   = 2'd2;
    localparam logic [3:0] c_md_load   = 4'(MULDIV_CYCLES - 2);

    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic       r_halted;

    logic [1:0] w_next_state;
    logic [3:0] w_next_cnt;
    logic       w_lu;
    logic       w_pc_write;
    logic       w_ifid_write;
    logic       w_idex_write;
    logic       w_ifid_flush;
    logic       w_idex_flush;
    logic       w_exmem_flush;

    assign w_lu = hz.ex_mem_read && (hz.ex_rd != REG_BITS'(0)) &&
                  ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                   (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));

    always_comb begin
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_idex_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        if (!rst) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_write  = 1'b0;
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
            w_exmem_flush = 1'b1;
        end else begin
            case (r_state)
                c_st_run: begin
                    // Branch wins: anything else seen in ID this cycle is wrong-path.
                    if (hz.ex_branch_taken) begin
                        w_ifid_flush = 1'b1;
                        w_idex_flush = 1'b1;
                    end else if (hz.ex_muldiv) begin
                        w_pc_write    = 1'b0;
                        w_ifid_write  = 1'b0;
                        w_idex_write  = 1'b0;
                        w_exmem_flush = 1'b1;
                        w_next_state  = c_st_muldiv;
                        w_next_cnt    = c_md_load;
                    end else if (w_lu) begin
                        w_pc_write   = 1'b0;
                        w_ifid_write = 1'b0;
                        w_idex_flush = 1'b1;
                    end else if (hz.id_halt) begin
                        w_pc_write   = 1'b0;
                        w_ifid_flush = 1'b1;
                        w_next_state = c_st_halt;
                    end
                end
                c_st_muldiv: begin
                    // cnt==0 is the release cycle; ex_muldiv is not looked at here.
                    if (r_cnt != 4'd0) begin
                        w_pc_write    = 1'b0;
                        w_ifid_write  = 1'b0;
                        w_idex_write  = 1'b0;
                        w_exmem_flush = 1'b1;
                        w_next_cnt    = r_cnt - 4'd1;
                    end else begin
                        w_next_state = c_st_run;
                    end
                end
                c_st_halt: begin
                    w_pc_write    = 1'b0;
                    w_ifid_write  = 1'b0;
                    w_ifid_flush  = 1'b1;
                    w_idex_flush  = 1'b1;
                    w_exmem_flush = 1'b1;
                end
                default: begin
                    w_next_state = c_st_run;
                    w_next_cnt   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= c_st_run;
            r_cnt    <= 4'd0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_cnt    <= w_next_cnt;
            r_halted <= (w_next_state == c_st_halt);
        end
    end

    assign hz.pc_write    = w_pc_write;
    assign hz.ifid_write  = w_ifid_write;
    assign hz.idex_write  = w_idex_write;
    assign hz.ifid_flush  = w_ifid_flush;
    assign hz.idex_flush  = w_idex_flush;
    assign hz.exmem_flush = w_exmem_flush;
    assign hz.halted      = r_halted;

`ifdef PIPECTRL_PERF_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_count <= 16'd0;
        end else if (!w_pc_write && (r_state != c_st_halt) &&
                     (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign hz.stall_count = r_stall_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
//  tb_pipeline_hazard_ctrl
//  Random + directed stimulus against a cycle-level behavioural reference.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;
    localparam int MC = 4;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    pipeline_hazard_ctrl_if #(.REG_BITS(4)) hz ();

    pipeline_hazard_ctrl #(.MULDIV_CYCLES(MC), .REG_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: pipeline status as "halted?" plus how many more cycles the
    // current mul/div op still occupies EX; 0 means no op in flight.
    bit m_halt;
    int m_md;
    int m_sc;

    always @(negedge clk) begin
        logic pw, iw, xw, ifl, xfl, mfl, lu;
        pw = 1; iw = 1; xw = 1; ifl = 0; xfl = 0; mfl = 0;
        lu = hz.ex_mem_read && hz.ex_rd != 4'd0 &&
             ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) ||
              (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));
        if (!rst) begin
            m_halt = 0; m_md = 0; m_sc = 0;
            pw = 0; iw = 0; xw = 0; ifl = 1; xfl = 1; mfl = 1;
        end else if (m_halt) begin
            pw = 0; iw = 0; ifl = 1; xfl = 1; mfl = 1;
        end else if (m_md > 1) begin
            pw = 0; iw = 0; xw = 0; mfl = 1;
        end else if (m_md == 1) begin
            pw = 1;
        end else if (hz.ex_branch_taken) begin
            ifl = 1; xfl = 1;
        end else if (hz.ex_muldiv) begin
            pw = 0; iw = 0; xw = 0; mfl = 1;
        end else if (lu) begin
            pw = 0; iw = 0; xfl = 1;
        end else if (hz.id_halt) begin
            pw = 0; ifl = 1;
        end
        chk("pc_write",    16'(hz.pc_write),    16'(pw));
        chk("ifid_write",  16'(hz.ifid_write),  16'(iw));
        chk("idex_write",  16'(hz.idex_write),  16'(xw));
        chk("ifid_flush",  16'(hz.ifid_flush),  16'(ifl));
        chk("idex_flush",  16'(hz.idex_flush),  16'(xfl));
        chk("exmem_flush", 16'(hz.exmem_flush), 16'(mfl));
        chk("halted",      16'(hz.halted),      16'(m_halt));
`ifdef PIPECTRL_PERF_EN
        chk("stall_count", hz.stall_count,      16'(m_sc));
`endif
        // Advance the reference to what the next rising edge produces.
        if (rst) begin
            if (!pw && !m_halt && m_sc < 65535) m_sc++;
            if (m_halt) m_halt = 1;
            else if (m_md > 0) m_md--;
            else if (hz.ex_branch_taken) m_md = 0;
            else if (hz.ex_muldiv) m_md = MC - 1;
            else if (!lu && hz.id_halt) m_halt = 1;
        end
    end

    task automatic idle();
        hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_use_rs1 = 0; hz.id_use_rs2 = 0;
        hz.id_halt = 0; hz.ex_mem_read = 0; hz.ex_rd = 0;
        hz.ex_branch_taken = 0; hz.ex_muldiv = 0;
    endtask

    task automatic rand_in();
        hz.id_rs1 = 4'($urandom_range(0, 3));
        hz.id_rs2 = 4'($urandom_range(0, 3));
        hz.id_use_rs1 = 1'($urandom);
        hz.id_use_rs2 = 1'($urandom);
        hz.id_halt = ($urandom_range(0, 47) == 0);
        hz.ex_mem_read = 1'($urandom);
        hz.ex_rd = 4'($urandom_range(0, 3));
        hz.ex_branch_taken = ($urandom_range(0, 5) == 0);
        hz.ex_muldiv = ($urandom_range(0, 11) == 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int stalls;
        n_pass = 0; n_total = 0;
        rst = 1'b1;
        idle();
        #1 rst = 1'b0;

        // Reset with random inputs
        repeat (3) begin rand_in(); step(); end
        at_sample();
        chk("rst_pc_write", 16'(hz.pc_write), 16'd0);
        chk("rst_exmem_flush", 16'(hz.exmem_flush), 16'd1);
        chk("rst_halted", 16'(hz.halted), 16'd0);
        step(); rst = 1'b1; idle();
        at_sample();
        chk("run_pc_write", 16'(hz.pc_write), 16'd1);
        chk("run_ifid_flush", 16'(hz.ifid_flush), 16'd0);

        // Load-use, then the same with ex_rd = 0
        step();
        hz.ex_mem_read = 1; hz.ex_rd = 3; hz.id_rs2 = 3; hz.id_use_rs2 = 1;
        at_sample();
        chk("lu_pc_write", 16'(hz.pc_write), 16'd0);
        chk("lu_idex_flush", 16'(hz.idex_flush), 16'd1);
        step(); idle();
        at_sample();
        chk("lu_after_pc_write", 16'(hz.pc_write), 16'd1);
        step();
        hz.ex_mem_read = 1; hz.ex_rd = 0; hz.id_rs2 = 0; hz.id_use_rs2 = 1;
        at_sample();
        chk("lu_r0_pc_write", 16'(hz.pc_write), 16'd1);

        // Branch beats halt and load-use
        step();
        hz.ex_mem_read = 1; hz.ex_rd = 2; hz.id_rs1 = 2; hz.id_use_rs1 = 1;
        hz.id_halt = 1; hz.ex_branch_taken = 1;
        at_sample();
        chk("br_ifid_flush", 16'(hz.ifid_flush), 16'd1);
        chk("br_idex_flush", 16'(hz.idex_flush), 16'd1);
        chk("br_pc_write", 16'(hz.pc_write), 16'd1);
        step(); idle();
        at_sample();
        chk("br_no_halt", 16'(hz.halted), 16'd0);

        // Mul/div held high, counted from a fresh reset
        step(); rst = 1'b0;
        step(); rst = 1'b1; hz.ex_muldiv = 1;
        stalls = 0;
        for (int i = 0; i < MC; i++) begin
            at_sample();
            if (!hz.pc_write && hz.exmem_flush) stalls++;
            if (i == MC - 1) chk("md_release_pc_write", 16'(hz.pc_write), 16'd1);
            if (i < MC - 1) step();
        end
        chk("md_stalls", 16'(stalls), 16'd3);
`ifdef PIPECTRL_PERF_EN
        chk("md_stall_count", hz.stall_count, 16'd3);
`endif
        step(); idle();

        // Halt and reset out of it
        step(); hz.id_halt = 1;
        step(); idle();
        at_sample();
        chk("hlt_halted", 16'(hz.halted), 16'd1);
        chk("hlt_pc_write", 16'(hz.pc_write), 16'd0);
        chk("hlt_flushes", 16'({hz.ifid_flush, hz.idex_flush, hz.exmem_flush}), 16'h7);
        stalls = 0;
        repeat (10) begin step(); if (hz.halted) stalls++; end
        chk("hlt_persist", 16'(stalls), 16'd10);
        rst = 1'b0;
        #1;
        chk("hlt_rst_halted", 16'(hz.halted), 16'd0);
        step(); rst = 1'b1;

        // Reset on the second mul/div stall cycle
        step(); hz.ex_muldiv = 1;
        step(); hz.ex_muldiv = 0; rst = 1'b0;
        #1;
        chk("mdrst_pc_write", 16'(hz.pc_write), 16'd0);
        step(); rst = 1'b1;
        at_sample();
        chk("mdrst_no_stall", 16'(hz.pc_write), 16'd1);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            step();
            rand_in();
            rst = ($urandom_range(0, 29) != 0);
        end
        step(); rst = 1'b1; idle();
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

`default_nettype wire
